// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry for the direct-mapped data cache.
//   state_e      controller FSM encoding
//   TAG_W/IDX_W/OFF_W  address split: tag [31:10], index [9:5], byte offset [4:0]
//   line_addr()  builds a line-aligned memory address from tag and index
package dcache_pkg;

  localparam int TAG_W  = 22;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 5;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    READMISS  = 2'd2,
    REFILL    = 2'd3
  } state_e;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag/data storage.
// Ports:
//   clk_i, rst_i   clock, synchronous active-low reset (clears valid and dirty only)
//   i_idx          line index, shared by the read and write port
//   o_valid/o_dirty/o_tag/o_line  combinational read of line i_idx
//   i_we           write strobe: writes tag and full line, sets valid, dirty = i_wdirty
//   i_wtag/i_wline/i_wdirty       write data
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     i_idx,
  output logic                 o_valid,
  output logic                 o_dirty,
  output logic [TAG_W-1:0]     o_tag,
  output logic [LINE_BITS-1:0] o_line,
  input  logic                 i_we,
  input  logic [TAG_W-1:0]     i_wtag,
  input  logic [LINE_BITS-1:0] i_wline,
  input  logic                 i_wdirty
);

  logic [LINES-1:0]     r_valid;
  logic [LINES-1:0]     r_dirty;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= i_wdirty;
    end
  end

  // Tag and data arrays are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_wtag;
      r_data[i_idx] <= i_wline;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Hits are served with no added latency; a miss raises p1_stall_o (pipeline
// halt) until the victim is written back (if dirty) and the line refilled.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   p1_addr_i/p1_data_i           CPU address and store data
//   p1_MemRead_i/p1_MemWrite_i    load/store request (both high = store)
//   p1_data_o                     load data, 0 unless a read hit
//   p1_stall_o                    pipeline halt
//   mem_data_i/mem_ack_i          refill line and one-cycle completion pulse
//   mem_data_o/mem_addr_o         write-back line, line-aligned address
//   mem_enable_o/mem_write_o      request valid, 1 = write-back / 0 = refill
// Optional (macro DCACHE_HITCNT_EN): hit_cnt_o, miss_cnt_o access counters.
//
// state     | meaning
// IDLE      | serving hits; a miss picks WRITEBACK (dirty victim) or READMISS
// WRITEBACK | victim line sent to memory, waiting for mem_ack_i
// READMISS  | refill read outstanding, line captured on mem_ack_i
// REFILL    | one settle cycle, no memory request, then IDLE
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES     = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
`ifdef DCACHE_HITCNT_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  state_e               r_state;
  logic                 r_mem_en;
  logic                 r_mem_wr;
  logic [31:0]          r_mem_addr;
  logic [LINE_BITS-1:0] r_mem_data;

  logic [TAG_W-1:0]     w_addr_tag;
  logic [IDX_W-1:0]     w_idx;
  logic [2:0]           w_word;
  logic                 w_req;
  logic                 w_valid;
  logic                 w_dirty;
  logic [TAG_W-1:0]     w_tag;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_hit;
  logic                 w_hit_ok;
  logic                 w_we;
  logic                 w_wdirty;
  logic [LINE_BITS-1:0] w_wline;

  assign w_addr_tag = p1_addr_i[31:10];
  assign w_idx      = p1_addr_i[9:5];
  assign w_word     = p1_addr_i[4:2];
  assign w_req      = p1_MemRead_i | p1_MemWrite_i;

  dcache_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_idx    (w_idx),
    .o_valid  (w_valid),
    .o_dirty  (w_dirty),
    .o_tag    (w_tag),
    .o_line   (w_line),
    .i_we     (w_we),
    .i_wtag   (w_addr_tag),
    .i_wline  (w_wline),
    .i_wdirty (w_wdirty)
  );

  assign w_hit = w_req & w_valid & (w_tag == w_addr_tag);
  // The line is already valid during REFILL, but the access is only
  // released once the FSM is back in IDLE.
  assign w_hit_ok = w_hit & (r_state == IDLE);

  assign p1_stall_o = w_req & ~w_hit_ok;
  assign p1_data_o  = (w_hit_ok & p1_MemRead_i & ~p1_MemWrite_i)
                      ? w_line[{w_word, 5'b0} +: WORD_W] : 32'd0;

  // Single array write port: refill on the READMISS ack, or a store hit
  // merged into the current line.
  always_comb begin
    w_we     = 1'b0;
    w_wdirty = 1'b0;
    w_wline  = w_line;
    if (r_state == READMISS && mem_ack_i) begin
      w_we    = 1'b1;
      w_wline = mem_data_i;
    end else if (w_hit_ok && p1_MemWrite_i) begin
      w_we     = 1'b1;
      w_wdirty = 1'b1;
      w_wline[{w_word, 5'b0} +: WORD_W] = p1_data_i;
    end
    if (!rst_i) begin
      w_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            r_mem_en <= 1'b1;
            if (w_valid && w_dirty) begin
              r_state    <= WRITEBACK;
              r_mem_wr   <= 1'b1;
              r_mem_addr <= line_addr(w_tag, w_idx);
              r_mem_data <= w_line;
            end else begin
              r_state    <= READMISS;
              r_mem_wr   <= 1'b0;
              r_mem_addr <= line_addr(w_addr_tag, w_idx);
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            r_state    <= READMISS;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= line_addr(w_addr_tag, w_idx);
          end
        end
        READMISS: begin
          if (mem_ack_i) begin
            r_state  <= REFILL;
            r_mem_en <= 1'b0;
          end
        end
        REFILL: begin
          r_state <= IDLE;
        end
        default: begin
          r_state  <= IDLE;
          r_mem_en <= 1'b0;
          r_mem_wr <= 1'b0;
        end
      endcase
    end
  end

  assign mem_enable_o = r_mem_en;
  assign mem_write_o  = r_mem_wr;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

`ifdef DCACHE_HITCNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        r_had_miss;

  // r_had_miss marks the access that is completing after its own miss so
  // it is not also counted as a hit.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_had_miss <= 1'b0;
    end else if (r_state == IDLE && w_req && !w_hit) begin
      r_miss_cnt <= r_miss_cnt + 32'd1;
      r_had_miss <= 1'b1;
    end else if (w_hit_ok) begin
      if (!r_had_miss) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      r_had_miss <= 1'b0;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
`ifdef DCACHE_HITCNT_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o)
`ifdef DCACHE_HITCNT_EN
    ,
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Backing memory: untouched words hold (byte address ^ 0xC0DE0000).
  logic [255:0] mem_store [logic [31:0]];

  function automatic logic [255:0] pat(input logic [31:0] la);
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = (la | (w << 2)) ^ 32'hC0DE_0000;
    return r;
  endfunction

  function automatic logic [255:0] mem_read(input logic [31:0] la);
    if (mem_store.exists(la)) return mem_store[la];
    return pat(la);
  endfunction

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } txn_t;
  txn_t mem_log[$];

  bit auto_mem = 1'b1;
  int mem_lat  = 10;

  // Memory responder: ack after mem_lat cycles of an enabled request.
  initial begin
    int cnt;
    txn_t t;
    cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (auto_mem) begin
        mem_ack_i = 1'b0;
        if (mem_enable_o) begin
          cnt++;
          if (cnt >= mem_lat) begin
            t.addr = mem_addr_o;
            t.wr   = mem_write_o;
            t.data = mem_data_o;
            mem_log.push_back(t);
            if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
            else mem_data_i = mem_read(mem_addr_o);
            mem_ack_i = 1'b1;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One access: drive, count stalled cycles (sampled mid-cycle), capture
  // p1_data_o on the releasing cycle, then drop the request.
  task automatic do_access(input logic [31:0] a, input logic [31:0] wd,
                           input logic rd, input logic wr,
                           output int stall_n, output logic [31:0] dout);
    @(posedge clk_i);
    #1;
    p1_addr_i     = a;
    p1_data_i     = wd;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    stall_n = 0;
    #4;
    while (p1_stall_o && stall_n < 300) begin
      stall_n++;
      @(posedge clk_i);
      #5;
    end
    if (stall_n >= 300) begin
      errors++;
      $display("FAIL access_timeout addr=%h stalled=%0d", a, stall_n);
    end
    dout = p1_data_o;
    @(posedge clk_i);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    int          lat;
    logic [31:0] exp_data;
    int          exp_stall;
    logic        exp_wb;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_rd_addr;
    int          wb_word;
    logic [31:0] wb_val;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } exp_t;
  exp_t exp_q[$];

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    int sn;
    logic [31:0] dout;
    exp_t e;
    txn_t t;

    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int sn;
    logic [31:0] dout;
    exp_t e;
    txn_t t;

    //            addr          wdata         rd wr lat data          stall wb  wb_addr       rd_addr      word val
    vecs[0]  = '{32'h0000_0404, 32'h0,        1, 0, 10, 32'hC0DE_0404, 12, 0, 32'h0,        32'h0000_0400, 0, 32'h0};
    vecs[1]  = '{32'h0000_0408, 32'hDEAD_BEEF, 0, 1, 10, 32'h0,        0,  0, 32'h0,        32'h0,        0, 32'h0};
    vecs[2]  = '{32'h0000_0408, 32'h0,        1, 0, 10, 32'hDEAD_BEEF, 0,  0, 32'h0,        32'h0,        0, 32'h0};
    vecs[3]  = '{32'h0000_040F, 32'h0,        1, 0, 10, 32'hC0DE_040C, 0,  0, 32'h0,        32'h0,        0, 32'h0};
    vecs[4]  = '{32'h0000_0808, 32'h0,        1, 0, 10, 32'hC0DE_0808, 22, 1, 32'h0000_0400, 32'h0000_0800, 2, 32'hDEAD_BEEF};
    vecs[5]  = '{32'h0000_0408, 32'h0,        1, 0, 3,  32'hDEAD_BEEF, 5,  0, 32'h0,        32'h0000_0400, 0, 32'h0};
    vecs[6]  = '{32'hFFFF_FFFC, 32'h1234_5678, 1, 1, 4,  32'h0,        6,  0, 32'h0,        32'hFFFF_FFE0, 0, 32'h0};
    vecs[7]  = '{32'hFFFF_FFFC, 32'h0,        1, 0, 4,  32'h1234_5678, 0,  0, 32'h0,        32'h0,        0, 32'h0};
    vecs[8]  = '{32'hFFFF_FFE1, 32'h0,        1, 0, 4,  32'h3F21_FFE0, 0,  0, 32'h0,        32'h0,        0, 32'h0};
    vecs[9]  = '{32'h0000_03FC, 32'h0,        1, 0, 2,  32'hC0DE_03FC, 6,  1, 32'hFFFF_FFE0, 32'h0000_03E0, 7, 32'h1234_5678};
    vecs[10] = '{32'hFFFF_FFFC, 32'h0,        1, 0, 2,  32'h1234_5678, 4,  0, 32'h0,        32'hFFFF_FFE0, 0, 32'h0};

    rst_i         = 1'b0;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    mem_data_i    = '0;
    mem_ack_i     = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #4;
    chk("rst_stall", {31'd0, p1_stall_o}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_enable_o}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_write_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_data_or", {31'd0, |mem_data_o}, 32'd0);
    chk("rst_p1_data", p1_data_o, 32'd0);

    for (int i = 0; i < NV; i++) begin
      mem_lat = vecs[i].lat;
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_stall});
      do_access(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, sn, dout);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_data", i), dout, e.data);
      chk($sformatf("v%0d_stall_cycles", i), sn, e.stall);
      if (vecs[i].exp_wb) begin
        if (mem_log.size() == 0) begin
          errors++; checks++;
          $display("FAIL v%0d_wb_missing actual=none expected=%h", i, vecs[i].exp_wb_addr);
        end else begin
          t = mem_log.pop_front();
          chk($sformatf("v%0d_wb_addr", i), t.addr, vecs[i].exp_wb_addr);
          chk($sformatf("v%0d_wb_write", i), {31'd0, t.wr}, 32'd1);
          chk($sformatf("v%0d_wb_word", i), t.data[vecs[i].wb_word*32 +: 32], vecs[i].wb_val);
        end
      end
      if (vecs[i].exp_stall != 0) begin
        if (mem_log.size() == 0) begin
          errors++; checks++;
          $display("FAIL v%0d_rd_missing actual=none expected=%h", i, vecs[i].exp_rd_addr);
        end else begin
          t = mem_log.pop_front();
          chk($sformatf("v%0d_rd_addr", i), t.addr, vecs[i].exp_rd_addr);
          chk($sformatf("v%0d_rd_write", i), {31'd0, t.wr}, 32'd0);
        end
      end
      chk($sformatf("v%0d_extra_txn", i), mem_log.size(), 32'd0);
      mem_log.delete();
    end

    // Reset while a refill read is outstanding; a late ack must be ignored.
    auto_mem = 1'b0;
    @(posedge clk_i);
    #1;
    p1_addr_i    = 32'h0000_1000;
    p1_MemRead_i = 1'b1;
    #4;
    chk("mr_stall_rise", {31'd0, p1_stall_o}, 32'd1);
    repeat (2) @(posedge clk_i);
    #5;
    chk("mr_mem_en", {31'd0, mem_enable_o}, 32'd1);
    chk("mr_mem_wr", {31'd0, mem_write_o}, 32'd0);
    chk("mr_mem_addr", mem_addr_o, 32'h0000_1000);
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    p1_MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #4;
    chk("mr_rst_mem_en", {31'd0, mem_enable_o}, 32'd0);
    chk("mr_rst_mem_addr", mem_addr_o, 32'd0);
    chk("mr_rst_stall", {31'd0, p1_stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    mem_data_i = '1;
    mem_ack_i  = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    #4;
    chk("late_ack_mem_en", {31'd0, mem_enable_o}, 32'd0);
    auto_mem = 1'b1;
    mem_lat  = 3;
    mem_log.delete();
    do_access(32'h0000_1000, 32'h0, 1'b1, 1'b0, sn, dout);
    chk("post_rst_stall_cycles", sn, 32'd5);
    chk("post_rst_data", dout, 32'hC0DE_1000);
    chk("post_rst_txns", mem_log.size(), 32'd1);
    // Everything was invalidated by reset, so a formerly resident line misses.
    do_access(32'h0000_03FC, 32'h0, 1'b1, 1'b0, sn, dout);
    chk("post_rst_old_line_stall", sn, 32'd5);
    chk("post_rst_old_line_data", dout, 32'hC0DE_03FC);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
